acq_sequencer: RTL and testbench

Sequences one ultrasonic/EMA acquisition shot in the 80 MHz domain: fire the EMA pulse, blank the receiver, capture N ADC samples into the sample buffer, then hand the frame to the FSMC readout side.
Owns the periodic trigger, the data_ready/ack handshake with the FSMC block, and the overrun and timeout status.
Sits between the PLL clock domain top level, the ADC capture path and the FSMC sample buffer.

---
 rtl/acq_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_acq_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
// acq_sequencer: sequences one acquisition shot in the 80 MHz domain.
// Fires the EMA pulse, blanks the receiver, captures N_SAMPLES ADC samples into the
// sample buffer and then holds data_ready until the FSMC side acknowledges the frame.
// Also owns the periodic auto-trigger and the sticky overrun / timeout status flags.
//
// Ports:
//   clk_80mhz    system clock from the PLL
//   rst_n        asynchronous active-low reset (from pll_locked)
//   trig_en      enable periodic auto-trigger
//   sw_trig      single-cycle software trigger
//   adc_data     ADC sample
//   adc_valid    sample strobe, one cycle per sample
//   host_ack     single-cycle pulse: FSMC side finished reading the frame
//   overrun_clr  clears overrun and timeout_err
//   pulse_p/n    EMA pulse legs (idle: p=0, n=1)
//   ctrl_sw      receiver protection switch, 1 = blanked
//   buf_we/waddr/wdata  registered sample-buffer write port
//   data_ready   frame complete and valid in buffer
//   busy         shot in progress (PULSE, BLANK or CAPTURE)
//   frame_cnt    completed frames, wraps
//   overrun      sticky: trigger dropped
//   timeout_err  sticky: capture aborted on an adc_valid gap
module acq_sequencer #(
  parameter int unsigned N_SAMPLES      = 10,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned PULSE_CYCLES   = 8,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter int unsigned PERIOD_CYCLES  = 240000000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk_80mhz,
  input  logic              rst_n,
  input  logic              trig_en,
  input  logic              sw_trig,
  input  logic [11:0]       adc_data,
  input  logic              adc_valid,
  input  logic              host_ack,
  input  logic              overrun_clr,
  output logic              pulse_p,
  output logic              pulse_n,
  output logic              ctrl_sw,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [11:0]       buf_wdata,
  output logic              data_ready,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int unsigned PhaseMax = (PULSE_CYCLES > BLANK_CYCLES) ? PULSE_CYCLES : BLANK_CYCLES;
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
  localparam int unsigned TmrW     = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned GapW     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PhaseW-1:0] PulseLast = PhaseW'(PULSE_CYCLES - 1);
  localparam logic [PhaseW-1:0] BlankLast = PhaseW'(BLANK_CYCLES - 1);
  localparam logic [TmrW-1:0]   TmrLast   = TmrW'(PERIOD_CYCLES - 1);
  localparam logic [GapW-1:0]   GapLast   = GapW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IdxLast   = ADDR_W'(N_SAMPLES - 1);

  typedef enum logic [2:0] {StIdle, StPulse, StBlank, StCapture, StReady} state_e;

  state_e              state_q, state_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [11:0]         wdata_q, wdata_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;
  logic                tick;
  logic                trigger;

  always_ff @(posedge clk_80mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      tmr_q       <= '0;
      gap_q       <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tmr_q       <= tmr_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    tmr_d       = tmr_q;
    gap_d       = gap_q;
    idx_d       = idx_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;
    tick        = 1'b0;

    // Clear first so that a coincident set event below takes priority.
    if (overrun_clr) begin
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end

    // Period timer runs in every state; only acceptance of its tick is state dependent.
    if (!trig_en) begin
      tmr_d = '0;
    end else if (tmr_q == TmrLast) begin
      tmr_d = '0;
      tick  = 1'b1;
    end else begin
      tmr_d = tmr_q + TmrW'(1);
    end

    trigger = tick | sw_trig;

    // Any trigger outside IDLE is dropped, including READY with a coincident host_ack.
    if (trigger && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        idx_d   = '0;
        phase_d = '0;
        gap_d   = '0;
        if (trigger) begin
          state_d = StPulse;
        end
      end
      StPulse: begin
        if (phase_q == PulseLast) begin
          phase_d = '0;
          state_d = StBlank;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StBlank: begin
        if (phase_q == BlankLast) begin
          phase_d = '0;
          gap_d   = '0;
          state_d = StCapture;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StCapture: begin
        if (adc_valid) begin
          we_d    = 1'b1;
          waddr_d = idx_q;
          wdata_d = adc_data;
          idx_d   = idx_q + ADDR_W'(1);
          gap_d   = '0;
          // Registered write and READY land on the same edge, so data_ready
          // rises in the same cycle as the final buffer write.
          if (idx_q == IdxLast) begin
            state_d     = StReady;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end else if (gap_q == GapLast) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StReady: begin
        if (host_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    pulse_p     = (state_q == StPulse);
    pulse_n     = ~pulse_p;
    ctrl_sw     = (state_q == StPulse) || (state_q == StBlank);
    data_ready  = (state_q == StReady);
    busy        = (state_q == StPulse) || (state_q == StBlank) || (state_q == StCapture);
    buf_we      = we_q;
    buf_waddr   = waddr_q;
    buf_wdata   = wdata_q;
    frame_cnt   = frame_cnt_q;
    overrun     = overrun_q;
    timeout_err = timeout_q;
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer (short period and timeout for simulation).
module tb_acq_sequencer;

  logic        clk_80mhz = 1'b0;
  logic        rst_n;
  logic        trig_en;
  logic        sw_trig;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic        host_ack;
  logic        overrun_clr;
  logic        pulse_p;
  logic        pulse_n;
  logic        ctrl_sw;
  logic        buf_we;
  logic [3:0]  buf_waddr;
  logic [11:0] buf_wdata;
  logic        data_ready;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        overrun;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  acq_sequencer #(
    .N_SAMPLES     (10),
    .ADDR_W        (4),
    .PULSE_CYCLES  (8),
    .BLANK_CYCLES  (16),
    .PERIOD_CYCLES (100),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_80mhz  (clk_80mhz),
    .rst_n      (rst_n),
    .trig_en    (trig_en),
    .sw_trig    (sw_trig),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .host_ack   (host_ack),
    .overrun_clr(overrun_clr),
    .pulse_p    (pulse_p),
    .pulse_n    (pulse_n),
    .ctrl_sw    (ctrl_sw),
    .buf_we     (buf_we),
    .buf_waddr  (buf_waddr),
    .buf_wdata  (buf_wdata),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk_80mhz = ~clk_80mhz;

  typedef struct {
    logic [11:0] data;
    logic [3:0]  exp_addr;
    logic        exp_ready;
  } cap_vec_t;

  cap_vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk_80mhz);
    #1;
  endtask

  task automatic wait_capture(input string name);
    int n;
    n = 0;
    while (!(busy && !ctrl_sw) && n < 100) begin
      step();
      n++;
    end
    check(name, {31'd0, (busy && !ctrl_sw)}, 32'd1);
  endtask

  task automatic feed(input int n, input logic [11:0] base);
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'b1;
      adc_data  = base + 12'(i);
      step();
    end
    adc_valid = 1'b0;
  endtask

  task automatic pulse_sw_trig();
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
  endtask

  task automatic ack();
    host_ack = 1'b1;
    step();
    host_ack = 1'b0;
  endtask

  // Strobes separated by one idle cycle; each write must appear right after its strobe.
  task automatic run_table(input string tag);
    for (int i = 0; i < 10; i++) begin
      adc_valid = 1'b1;
      adc_data  = vecs[i].data;
      step();
      adc_valid = 1'b0;
      check({tag, "_we"}, {31'd0, buf_we}, 32'd1);
      check({tag, "_waddr"}, {28'd0, buf_waddr}, {28'd0, vecs[i].exp_addr});
      check({tag, "_wdata"}, {20'd0, buf_wdata}, {20'd0, vecs[i].data});
      check({tag, "_ready"}, {31'd0, data_ready}, {31'd0, vecs[i].exp_ready});
      step();
      check({tag, "_we_low"}, {31'd0, buf_we}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pl, nl, cl, n, rises;
    int rise_t [3];
    logic prev_p;

    vecs[0] = '{12'h100, 4'd0, 1'b0};
    vecs[1] = '{12'h101, 4'd1, 1'b0};
    vecs[2] = '{12'h102, 4'd2, 1'b0};
    vecs[3] = '{12'h103, 4'd3, 1'b0};
    vecs[4] = '{12'h104, 4'd4, 1'b0};
    vecs[5] = '{12'h105, 4'd5, 1'b0};
    vecs[6] = '{12'h106, 4'd6, 1'b0};
    vecs[7] = '{12'h107, 4'd7, 1'b0};
    vecs[8] = '{12'h108, 4'd8, 1'b0};
    vecs[9] = '{12'h109, 4'd9, 1'b1};

    rst_n = 1'b0; trig_en = 1'b0; sw_trig = 1'b0; adc_data = '0;
    adc_valid = 1'b0; host_ack = 1'b0; overrun_clr = 1'b0;
    repeat (3) step();
    check("rst_pulse_p", {31'd0, pulse_p}, 32'd0);
    check("rst_pulse_n", {31'd0, pulse_n}, 32'd1);
    check("rst_ctrl_sw", {31'd0, ctrl_sw}, 32'd0);
    check("rst_buf_we", {31'd0, buf_we}, 32'd0);
    check("rst_waddr", {28'd0, buf_waddr}, 32'd0);
    check("rst_wdata", {20'd0, buf_wdata}, 32'd0);
    check("rst_ready", {31'd0, data_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // Frame 1: pulse/blank widths then table-driven capture.
    pulse_sw_trig();
    check("f1_pulse_start", {31'd0, pulse_p}, 32'd1);
    pl = 0; nl = 0; cl = 0;
    for (int i = 0; i < 100; i++) begin
      if (!ctrl_sw) break;
      if (pulse_p) pl++;
      if (!pulse_n) nl++;
      cl++;
      step();
    end
    check("f1_pulse_p_len", pl, 8);
    check("f1_pulse_n_len", nl, 8);
    check("f1_ctrl_sw_len", cl, 24);
    run_table("f1");
    check("f1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("f1_ready_hold", {31'd0, data_ready}, 32'd1);
    adc_valid = 1'b1; adc_data = 12'hABC;
    step();
    adc_valid = 1'b0;
    check("f1_valid_in_ready", {31'd0, buf_we}, 32'd0);
    ack();
    check("f1_ack_ready", {31'd0, data_ready}, 32'd0);
    check("f1_ack_busy", {31'd0, busy}, 32'd0);
    check("f1_no_overrun", {31'd0, overrun}, 32'd0);

    // Frame 2: back-to-back samples.
    pulse_sw_trig();
    wait_capture("f2_capture");
    feed(10, 12'h200);
    check("f2_ready", {31'd0, data_ready}, 32'd1);
    check("f2_last_waddr", {28'd0, buf_waddr}, 32'd9);
    check("f2_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    ack();

    // Frame 3: triggers dropped in CAPTURE and in READY with a coincident ack.
    pulse_sw_trig();
    wait_capture("f3_capture");
    feed(3, 12'h300);
    pulse_sw_trig();
    check("f3_ovr_capture", {31'd0, overrun}, 32'd1);
    check("f3_no_pulse_cap", {31'd0, pulse_p}, 32'd0);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("f3_ovr_clr", {31'd0, overrun}, 32'd0);
    feed(7, 12'h303);
    check("f3_ready", {31'd0, data_ready}, 32'd1);
    check("f3_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    sw_trig = 1'b1; host_ack = 1'b1;
    step();
    sw_trig = 1'b0; host_ack = 1'b0;
    check("f3_ovr_ready_ack", {31'd0, overrun}, 32'd1);
    check("f3_ack_honoured", {31'd0, data_ready}, 32'd0);
    check("f3_idle_busy", {31'd0, busy}, 32'd0);
    step();
    check("f3_no_pulse_late", {31'd0, pulse_p}, 32'd0);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("f3_ovr_clr2", {31'd0, overrun}, 32'd0);

    // Frame 4: clear coinciding with a set event; set wins.
    pulse_sw_trig();
    sw_trig = 1'b1; overrun_clr = 1'b1;
    step();
    sw_trig = 1'b0; overrun_clr = 1'b0;
    check("f4_set_wins", {31'd0, overrun}, 32'd1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    wait_capture("f4_capture");
    feed(10, 12'h400);
    check("f4_frame_cnt", {16'd0, frame_cnt}, 32'd4);
    ack();

    // Timeout: 4 samples then silence.
    pulse_sw_trig();
    wait_capture("to_capture");
    feed(4, 12'h500);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check("to_idle_cycles", n, 64);
    check("to_err", {31'd0, timeout_err}, 32'd1);
    check("to_ready", {31'd0, data_ready}, 32'd0);
    check("to_frame_cnt", {16'd0, frame_cnt}, 32'd4);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("to_err_clr", {31'd0, timeout_err}, 32'd0);

    // Periodic trigger with an immediately acknowledging host.
    trig_en = 1'b1;
    rises = 0;
    prev_p = pulse_p;
    for (int t = 0; t < 500 && rises < 3; t++) begin
      adc_valid = busy && !ctrl_sw;
      adc_data  = 12'h600;
      host_ack  = data_ready;
      step();
      if (pulse_p && !prev_p) begin
        rise_t[rises] = t;
        rises++;
      end
      prev_p = pulse_p;
    end
    check("per_rises", rises, 3);
    check("per_gap1", rise_t[1] - rise_t[0], 100);
    check("per_gap2", rise_t[2] - rise_t[1], 100);
    trig_en = 1'b0;
    rises = 0;
    for (int t = 0; t < 300; t++) begin
      adc_valid = busy && !ctrl_sw;
      host_ack  = data_ready;
      step();
      if (pulse_p && !prev_p) rises++;
      prev_p = pulse_p;
    end
    adc_valid = 1'b0; host_ack = 1'b0;
    check("per_off_rises", rises, 0);
    check("per_frame_cnt", {16'd0, frame_cnt}, 32'd7);
    check("per_no_overrun", {31'd0, overrun}, 32'd0);

    // Asynchronous reset in the middle of CAPTURE.
    pulse_sw_trig();
    wait_capture("rs_capture");
    feed(5, 12'h700);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_busy", {31'd0, busy}, 32'd0);
    check("rs_buf_we", {31'd0, buf_we}, 32'd0);
    check("rs_waddr", {28'd0, buf_waddr}, 32'd0);
    check("rs_wdata", {20'd0, buf_wdata}, 32'd0);
    check("rs_pulse_n", {31'd0, pulse_n}, 32'd1);
    check("rs_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    pulse_sw_trig();
    wait_capture("rs2_capture");
    run_table("rs2");
    check("rs2_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
